// File: rtl/commit_retire_unit.sv
// Two-wide commit/retire stage: updates the architectural register file, counts
// retired instructions and queues superseded physical registers for the free list.
module commit_retire_unit #(
    parameter int FREE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid_1,
    input  logic        commit_valid_2,
    input  logic [5:0]  commit_dest_1,
    input  logic [5:0]  commit_dest_2,
    input  logic [5:0]  free_oldDest_1,
    input  logic [5:0]  free_oldDest_2,
    input  logic [31:0] commit_value_1,
    input  logic [31:0] commit_value_2,
    input  logic [4:0]  commit_archDest_1,
    input  logic [4:0]  commit_archDest_2,
    output logic        commit_ready,
    output logic        free_valid,
    output logic [5:0]  free_preg,
    input  logic        free_ready,
    input  logic [4:0]  arch_rd_addr,
    output logic [31:0] arch_rd_data,
    output logic [31:0] retired_count
);
    localparam int PW = $clog2(FREE_DEPTH);

    logic [31:0] regs_q [32];
    logic [5:0]  fifo_q [FREE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    logic [31:0]   retired_q, retired_d;

    logic acc_1, acc_2, push_1, push_2, pop;
    logic [PW-1:0] wr_idx_2;

    // Physical destinations are tracked upstream; they are not needed here.
    logic unused_dest_s;
    assign unused_dest_s = ^{commit_dest_1, commit_dest_2};

    // Ready depends only on registered occupancy so a dual push can never overflow.
    assign commit_ready = (occ_q <= (PW+1)'(FREE_DEPTH - 2));
    assign acc_1  = commit_valid_1 & commit_ready;
    assign acc_2  = commit_valid_2 & commit_ready;
    assign push_1 = acc_1 & (commit_archDest_1 != 5'd0);
    assign push_2 = acc_2 & (commit_archDest_2 != 5'd0);
    assign pop    = free_valid & free_ready;

    assign free_valid    = (occ_q != '0);
    assign free_preg     = fifo_q[rd_ptr_q];
    assign retired_count = retired_q;
    assign arch_rd_data  = (arch_rd_addr == 5'd0) ? 32'd0 : regs_q[arch_rd_addr];

    // Next-state arithmetic for pointers, occupancy and retire counter.
    always_comb begin
        wr_idx_2  = wr_ptr_q + PW'(push_1);
        wr_ptr_d  = wr_ptr_q + PW'(push_1) + PW'(push_2);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        occ_d     = occ_q + (PW+1)'(push_1) + (PW+1)'(push_2) - (PW+1)'(pop);
        retired_d = retired_q + 32'(acc_1) + 32'(acc_2);
    end

    // State update; slot 2 is written after slot 1 so the younger value wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            retired_q <= 32'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
            for (int i = 0; i < FREE_DEPTH; i++) fifo_q[i] <= 6'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            retired_q <= retired_d;
            if (push_1) begin
                regs_q[commit_archDest_1] <= commit_value_1;
                fifo_q[wr_ptr_q]          <= free_oldDest_1;
            end
            if (push_2) begin
                regs_q[commit_archDest_2] <= commit_value_2;
                fifo_q[wr_idx_2]          <= free_oldDest_2;
            end
        end
    end
endmodule
